// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RV32I control path: opcodes, ALU codes, mux selects, FSM states.
// Constants only; no logic, no latency, no backpressure.
package riscv_pkg;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  typedef logic [3:0] state_t;

  localparam state_t S_FETCH    = 4'd0;
  localparam state_t S_DECODE   = 4'd1;
  localparam state_t S_MEMADR   = 4'd2;
  localparam state_t S_MEMREAD  = 4'd3;
  localparam state_t S_MEMWB    = 4'd4;
  localparam state_t S_MEMWRITE = 4'd5;
  localparam state_t S_EXECR    = 4'd6;
  localparam state_t S_EXECI    = 4'd7;
  localparam state_t S_ALUWB    = 4'd8;
  localparam state_t S_BEQ      = 4'd9;
  localparam state_t S_JAL      = 4'd10;
  localparam state_t S_HALT     = 4'd11;

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// Combinational funct decode to ALU code plus instruction legality check.
// Zero latency; no handshake, pure function of the instruction fields.
module alu_decoder
  import riscv_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [3:0] alu_control,
  output logic       legal
);

  logic is_r;
  logic f3_ok;

  assign is_r = (opcode == OP_R);

  always_comb begin
    f3_ok       = 1'b1;
    alu_control = ALU_ADD;
    case (funct3)
      3'b000:  alu_control = (is_r && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_control = ALU_SLT;
      3'b110:  alu_control = ALU_OR;
      3'b111:  alu_control = ALU_AND;
      default: f3_ok = 1'b0;
    endcase
  end

  // funct3 only matters for the ALU classes; memory, branch and jump ignore it
  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_LW, OP_SW, OP_BEQ, OP_JAL: legal = 1'b1;
      OP_R, OP_I:                   legal = f3_ok;
      default:                      legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle RV32I core: sequences fetch/decode/execute/memory/writeback.
// 3-5 cycles per instruction; FETCH, MEMREAD and MEMWRITE stall until mem_ready.
module multicycle_control
  import riscv_pkg::*;
#(
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [3:0] alu_control,
  output logic       illegal_instr,
  output logic       halted
);

  state_t     state_q, state_d;
  logic [3:0] dec_alu;
  logic       dec_legal;
  logic       pc_write_c, mem_write_c, ir_write_c, reg_write_c;

  alu_decoder u_alu_decoder (
    .opcode      (opcode),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .alu_control (dec_alu),
    .legal       (dec_legal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    case (opcode)
      OP_SW:   imm_src = IMM_S;
      OP_BEQ:  imm_src = IMM_B;
      OP_JAL:  imm_src = IMM_J;
      default: imm_src = IMM_I;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    pc_write_c    = 1'b0;
    mem_write_c   = 1'b0;
    ir_write_c    = 1'b0;
    reg_write_c   = 1'b0;
    adr_src       = 1'b0;
    result_src    = RES_ALUOUT;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_RS2;
    alu_control   = ALU_AND;
    illegal_instr = 1'b0;
    halted        = 1'b0;
    case (state_q)
      S_FETCH: begin
        alu_src_b   = SRCB_FOUR;
        alu_control = ALU_ADD;
        result_src  = RES_ALU;
        ir_write_c  = mem_ready;
        pc_write_c  = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        // precompute the branch target into ALUOut while decoding
        alu_src_a   = SRCA_OLDPC;
        alu_src_b   = SRCB_IMM;
        alu_control = ALU_ADD;
        if (!dec_legal) begin
          illegal_instr = 1'b1;
          state_d       = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
        end else begin
          case (opcode)
            OP_LW, OP_SW: state_d = S_MEMADR;
            OP_R:         state_d = S_EXECR;
            OP_I:         state_d = S_EXECI;
            OP_BEQ:       state_d = S_BEQ;
            OP_JAL:       state_d = S_JAL;
            default:      state_d = S_FETCH;
          endcase
        end
      end
      S_MEMADR: begin
        alu_src_a   = SRCA_RS1;
        alu_src_b   = SRCB_IMM;
        alu_control = ALU_ADD;
        state_d     = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src  = RES_RDATA;
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src     = 1'b1;
        mem_write_c = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a   = SRCA_RS1;
        alu_control = dec_alu;
        state_d     = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a   = SRCA_RS1;
        alu_src_b   = SRCB_IMM;
        alu_control = dec_alu;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a   = SRCA_RS1;
        alu_control = ALU_SUB;
        pc_write_c  = zero;
        state_d     = S_FETCH;
      end
      S_JAL: begin
        alu_src_a   = SRCA_OLDPC;
        alu_src_b   = SRCB_FOUR;
        alu_control = ALU_ADD;
        pc_write_c  = 1'b1;
        state_d     = S_ALUWB;
      end
      S_HALT: halted = 1'b1;
      default: state_d = S_FETCH;
    endcase
  end

  // the state register is already FETCH during reset; masking keeps FETCH's strobes quiet too
  assign pc_write  = pc_write_c  & rst_n;
  assign mem_write = mem_write_c & rst_n;
  assign ir_write  = ir_write_c  & rst_n;
  assign reg_write = reg_write_c & rst_n;

endmodule
